// File: rtl/alu_pkg.sv
// Shared constants for the ALU datapath and its sequencing controller.
// Used by alu_core and alu_datapath (optional flags build: ALU_FLAGS_EN).
package alu_pkg;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Control-vector bit positions, shared with the controller
    localparam int LD1  = 4;
    localparam int LD2  = 3;
    localparam int SEL1 = 2;
    localparam int OP   = 1;
    localparam int EN   = 0;

    localparam int FLAG_N = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 0;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;
endpackage

// File: rtl/alu_core.sv
// Combinational add/subtract unit with {N,V,C,Z} status.
// Flag logic is only built when ALU_FLAGS_EN is defined; otherwise flags_o is 0.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             op_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       flags_o
);

`ifdef ALU_FLAGS_EN
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;

    // Subtract is A + ~B + 1, so C=1 means no borrow
    always_comb begin
        b_eff    = (op_i == OP_SUB) ? ~b_i : b_i;
        sum_ext  = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op_i == OP_SUB)};
        result_o = sum_ext[WIDTH-1:0];
        flags_o  = 4'b0000;
        flags_o[FLAG_N] = result_o[WIDTH-1];
        flags_o[FLAG_V] = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (result_o[WIDTH-1] != a_i[WIDTH-1]);
        flags_o[FLAG_C] = sum_ext[WIDTH];
        flags_o[FLAG_Z] = (result_o == '0);
    end
`else
    assign result_o = (op_i == OP_SUB) ? (a_i - b_i) : (a_i + b_i);
    assign flags_o  = 4'b0000;
`endif

endmodule

// File: rtl/alu_datapath.sv
// Operand registers, A-mux and one-deep valid/ready output register around alu_core.
// Define ALU_FLAGS_EN to build the registered {N,V,C,Z} flags; otherwise flags is 0.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ld_1,
    input  logic             ld_2,
    input  logic             sel_1,
    input  logic             op,
    input  logic             en,
    output logic [WIDTH-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       flags,
    output logic             ovf_err,
    output logic [CNT_W-1:0] op_count
);

    // Handshake: a transfer happens on a rising edge where res_valid & res_ready;
    // res_data/flags are held while res_valid & !res_ready. res_valid is state_q.
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [WIDTH-1:0] alu_res, a_mux;
    logic [3:0]       alu_flags;
    logic [0:0]       state_q, state_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_res, xfer;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op),
        .result_o (alu_res),
        .flags_o  (alu_flags)
    );

    assign a_mux = sel_1 ? data_in : alu_res;

    always_comb begin
        xfer     = (state_q == ST_FULL) && res_ready;
        load_res = en && ((state_q == ST_EMPTY) || res_ready);
        a_d      = ld_1 ? a_mux : a_q;
        b_d      = ld_2 ? data_in : b_q;
        res_d    = load_res ? alu_res : res_q;
        state_d  = state_q;
        if (load_res) begin
            state_d = ST_FULL;
        end else if (xfer) begin
            state_d = ST_EMPTY;
        end
        // A result arriving while the register is full and stalled is lost
        ovf_d = ovf_q | (en && (state_q == ST_FULL) && !res_ready);
        cnt_d = xfer ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            state_q <= ST_EMPTY;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ALU_FLAGS_EN
    logic [3:0] flags_q, flags_d;

    assign flags_d = load_res ? alu_flags : flags_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`else
    assign flags = alu_flags;
`endif

    assign res_data  = res_q;
    assign res_valid = (state_q == ST_FULL);
    assign ovf_err   = ovf_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_datapath.sv
// Directed bench for alu_datapath: reference model, expected-result queue, summary line.
// A second instance with CNT_W=2 checks counter wrap.
module tb_alu_datapath;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int CW = 8;
`ifdef ALU_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          ld_1 = 1'b0, ld_2 = 1'b0, sel_1 = 1'b0, op = 1'b0, en = 1'b0;
    logic          res_ready = 1'b0;
    logic [W-1:0]  res_data, res_data2;
    logic          res_valid, res_valid2;
    logic [3:0]    flags, flags2;
    logic          ovf_err, ovf_err2;
    logic [CW-1:0] op_count;
    logic [1:0]    op_count2;

    alu_datapath #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .ld_1(ld_1), .ld_2(ld_2), .sel_1(sel_1), .op(op), .en(en),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .flags(flags), .ovf_err(ovf_err), .op_count(op_count)
    );

    alu_datapath #(.WIDTH(W), .CNT_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .ld_1(ld_1), .ld_2(ld_2), .sel_1(sel_1), .op(op), .en(en),
        .res_data(res_data2), .res_valid(res_valid2), .res_ready(res_ready),
        .flags(flags2), .ovf_err(ovf_err2), .op_count(op_count2)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    logic [W-1:0]   ma, mb;
    logic           mvalid, movf;
    int             mcnt;
    logic [W+3:0]   exp_q[$];

    // Reference arithmetic with plain integers: {flags, result}
    function automatic logic [W+3:0] model_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic o);
        int ua, ub, sa, sb, full, sres;
        logic [W-1:0] r;
        logic n, v, c, z;
        logic [3:0] f;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 2**(W-1)) ? ua - 2**W : ua;
        sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
        if (o == OP_ADD) begin
            full = ua + ub;
            sres = sa + sb;
            c    = (full >= 2**W);
        end else begin
            full = ua - ub;
            sres = sa - sb;
            c    = (ua >= ub);
        end
        r = full[W-1:0];
        v = (sres > 2**(W-1) - 1) || (sres < -(2**(W-1)));
        n = r[W-1];
        z = (r == '0);
        f = FLAGS_ON ? {n, v, c, z} : 4'b0000;
        return {f, r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        check("res_valid", 32'(res_valid), 32'(mvalid));
        check("ovf_err", 32'(ovf_err), 32'(movf));
        check("op_count", 32'(op_count), mcnt % (2**CW));
        check("res_valid_w2", 32'(res_valid2), 32'(mvalid));
        check("ovf_err_w2", 32'(ovf_err2), 32'(movf));
        check("op_count_w2", 32'(op_count2), mcnt % 4);
    endtask

    // Called at a falling edge: drive controls, score any transfer, advance one cycle.
    task automatic step(input logic l1, input logic l2, input logic s1, input logic o,
                        input logic e, input logic [W-1:0] din, input logic rdy);
        logic [W+3:0] exp_now, head;
        logic xf;
        ld_1 = l1; ld_2 = l2; sel_1 = s1; op = o; en = e;
        data_in = din; res_ready = rdy;
        exp_now = model_alu(ma, mb, o);
        xf = mvalid && rdy;
        if (xf && exp_q.size() > 0) begin
            head = exp_q.pop_front();
            check("res_data", 32'(res_data), 32'(head[W-1:0]));
            check("flags", 32'(flags), 32'(head[W+3:W]));
            check("res_data_w2", 32'(res_data2), 32'(head[W-1:0]));
            check("flags_w2", 32'(flags2), 32'(head[W+3:W]));
        end
        if (l1) ma = s1 ? din : exp_now[W-1:0];
        if (l2) mb = din;
        if (e && (!mvalid || rdy)) begin
            exp_q.push_back(exp_now);
            mvalid = 1'b1;
        end else begin
            if (e) movf = 1'b1;
            if (xf) mvalid = 1'b0;
        end
        if (xf) mcnt++;
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) begin
            {ld_1, ld_2, sel_1, op, en} = 5'($urandom_range(0, 31));
            data_in   = W'($urandom_range(0, 2**W - 1));
            res_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
        end
        ma = '0; mb = '0; mvalid = 1'b0; movf = 1'b0; mcnt = 0;
        exp_q.delete();
        check("rst_res_data", 32'(res_data), 32'h0);
        check("rst_flags", 32'(flags), 32'h0);
        check_state();
        rst_n = 1'b1;
        {ld_1, ld_2, sel_1, op, en} = 5'b00000;
        res_ready = 1'b0;
    endtask

    initial begin
        ma = '0; mb = '0; mvalid = 1'b0; movf = 1'b0; mcnt = 0;
        @(negedge clk);
        do_reset(2);

        // Idle after reset: outputs stay at zero
        step(0, 0, 0, 0, 0, 8'hAA, 1);
        step(0, 0, 0, 1, 0, 8'h55, 0);
        check("idle_res_data", 32'(res_data), 32'h0);
        check("idle_flags", 32'(flags), 32'h0);

        // Add 7F + 01
        step(1, 0, 1, 0, 0, 8'h7F, 0);
        step(0, 1, 0, 0, 0, 8'h01, 0);
        step(0, 0, 0, OP_ADD, 1, 8'h00, 1);
        check("add_res", 32'(res_data), 32'h80);
        check("add_flags", 32'(flags), FLAGS_ON ? 32'hC : 32'h0);
        step(0, 0, 0, 0, 0, 8'h00, 1);
        check("add_count", 32'(op_count), 32'd1);

        // Subtract 5 - 5, then 3 - 5
        step(1, 0, 1, 0, 0, 8'h05, 0);
        step(0, 1, 0, 0, 0, 8'h05, 0);
        step(0, 0, 0, OP_SUB, 1, 8'h00, 0);
        check("sub_eq_res", 32'(res_data), 32'h00);
        check("sub_eq_flags", 32'(flags), FLAGS_ON ? 32'h3 : 32'h0);
        step(1, 0, 1, 0, 0, 8'h03, 1);
        step(0, 1, 0, 0, 0, 8'h05, 0);
        step(0, 0, 0, OP_SUB, 1, 8'h00, 0);
        check("sub_neg_res", 32'(res_data), 32'hFE);
        check("sub_neg_flags", 32'(flags), FLAGS_ON ? 32'h8 : 32'h0);
        step(0, 0, 0, 0, 0, 8'h00, 1);

        // Accumulate: A=1, B=3, three ld_1 pulses from the ALU; en on the third
        step(1, 0, 1, 0, 0, 8'h01, 0);
        step(0, 1, 0, 0, 0, 8'h03, 0);
        step(1, 0, 0, OP_ADD, 0, 8'hFF, 0);
        step(1, 0, 0, OP_ADD, 0, 8'hFF, 0);
        step(1, 0, 0, OP_ADD, 1, 8'hFF, 0);
        check("acc_res", 32'(res_data), 32'h0A);
        step(0, 0, 0, 0, 0, 8'h00, 1);

        // Backpressure: second result is dropped, first is held
        do_reset(1);
        step(1, 0, 1, 0, 0, 8'h10, 0);
        step(0, 1, 0, 0, 0, 8'h20, 0);
        step(0, 0, 0, OP_ADD, 1, 8'h00, 0);
        step(0, 1, 0, 0, 0, 8'h01, 0);
        step(0, 0, 0, OP_ADD, 1, 8'h00, 0);
        check("bp_hold", 32'(res_data), 32'h30);
        check("bp_ovf", 32'(ovf_err), 32'h1);
        step(0, 0, 0, 0, 0, 8'h00, 1);
        check("bp_valid", 32'(res_valid), 32'h0);
        check("bp_count", 32'(op_count), 32'd1);
        check("bp_ovf_sticky", 32'(ovf_err), 32'h1);

        // Back-to-back: en on four cycles with ready high
        do_reset(1);
        step(1, 0, 1, 0, 0, 8'h02, 1);
        step(0, 1, 0, 0, 0, 8'h01, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, OP_ADD, 1, 8'h00, 1);
        step(0, 0, 0, 0, 0, 8'h00, 1);
        check("b2b_count", 32'(op_count), 32'd4);
        check("b2b_count_wrap", 32'(op_count2), 32'd0);
        check("b2b_ovf", 32'(ovf_err), 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 W'($urandom_range(0, 2**W - 1)), 1'($urandom_range(0, 1)));
        end
        step(0, 0, 0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 0, 0, 8'h00, 1);

        // Reset with a pending result discards it without counting
        step(1, 0, 1, 0, 0, 8'h44, 0);
        step(0, 0, 0, OP_ADD, 1, 8'h00, 0);
        do_reset(1);
        step(0, 0, 0, OP_SUB, 1, 8'h00, 1);
        check("post_rst_res", 32'(res_data), 32'h00);
        step(0, 0, 0, 0, 0, 8'h00, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
